// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data load/store.
// Each access holds the memory for MEM_LAT cycles, then pulses the owner's done for one cycle.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    generate
        if (MEM_LAT < 1) begin : gLatCheck
            $error("mem_port_arbiter: MEM_LAT must be >= 1");
        end
    endgenerate

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   waitCnt, waitCntNext;
    logic               lastGrant, lastGrantNext;
    logic               accessWrite, accessWriteNext;
    logic               pickData;
    logic               grantNext, memEnNext, memWrNext, busyNext;
    logic               ifDoneNext, dDoneNext;
    logic [ADDR_W-1:0]  memAddrNext;
    logic [DATA_W-1:0]  memWdataNext, ifRdataNext, dRdataNext;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        stateNext       = state;
        waitCntNext     = waitCnt;
        lastGrantNext   = lastGrant;
        accessWriteNext = accessWrite;
        grantNext       = grant_id;
        memEnNext       = 1'b0;
        memWrNext       = 1'b0;
        busyNext        = 1'b0;
        ifDoneNext      = 1'b0;
        dDoneNext       = 1'b0;
        memAddrNext     = mem_addr;
        memWdataNext    = mem_wdata;
        ifRdataNext     = if_rdata;
        dRdataNext      = d_rdata;
        // Data wins when it is the only requester, or on a tie when fetch had the last grant.
        pickData        = d_req & (~if_req | ~lastGrant);
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grantNext       = pickData;
                    lastGrantNext   = pickData;
                    accessWriteNext = pickData & d_we;
                    memAddrNext     = pickData ? d_addr : if_addr;
                    memWdataNext    = pickData ? d_wdata : mem_wdata;
                    memWrNext       = pickData & d_we;
                    memEnNext       = 1'b1;
                    busyNext        = 1'b1;
                    waitCntNext     = CNT_W'(MEM_LAT);
                    stateNext       = ACCESS;
                end else begin
                    stateNext       = IDLE;
                end
            end
            ACCESS: begin
                busyNext = 1'b1;
                if (waitCnt == CNT_W'(1)) begin
                    waitCntNext = {CNT_W{1'b0}};
                    stateNext   = DONE;
                    ifDoneNext  = ~grant_id;
                    dDoneNext   = grant_id;
                    if (!grant_id) begin
                        ifRdataNext = mem_rdata;
                    end else if (!accessWrite) begin
                        dRdataNext  = mem_rdata;
                    end else begin
                        dRdataNext  = d_rdata;
                    end
                end else begin
                    waitCntNext = waitCnt - CNT_W'(1);
                    memEnNext   = 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, counter and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            waitCnt     <= {CNT_W{1'b0}};
            lastGrant   <= 1'b1;
            accessWrite <= 1'b0;
            grant_id    <= 1'b0;
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            busy        <= 1'b0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            if_rdata    <= {DATA_W{1'b0}};
            d_rdata     <= {DATA_W{1'b0}};
        end else begin
            state       <= stateNext;
            waitCnt     <= waitCntNext;
            lastGrant   <= lastGrantNext;
            accessWrite <= accessWriteNext;
            grant_id    <= grantNext;
            mem_en      <= memEnNext;
            mem_wr      <= memWrNext;
            busy        <= busyNext;
            if_done     <= ifDoneNext;
            d_done      <= dDoneNext;
            mem_addr    <= memAddrNext;
            mem_wdata   <= memWdataNext;
            if_rdata    <= ifRdataNext;
            d_rdata     <= dRdataNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and a small registered-read memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;
    logic        grant_id;

    int checks = 0;
    int errors = 0;
    int ifDoneCnt = 0;
    int dDoneCnt = 0;
    logic [31:0] memArr [0:15];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle registered read, write on mem_wr.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) memArr[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= memArr[mem_addr[5:2]];
        end
    end

    // Done pulse counters.
    always @(negedge clk) begin
        if (if_done === 1'b1) ifDoneCnt++;
        if (d_done === 1'b1)  dDoneCnt++;
    end

    task automatic nxt(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        nxt(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({mem_en, mem_wr, busy, grant_id, if_done, d_done} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", {mem_en, mem_wr, busy, grant_id, if_done, d_done});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0010;
        nxt();
        checks++;
        if ({mem_en, mem_wr, busy, grant_id} !== 4'b1010 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL fetch_access1: en/wr/busy/gnt=%b addr=%h want 1010 addr=10", {mem_en, mem_wr, busy, grant_id}, mem_addr);
        end
        nxt();
        checks++;
        if ({mem_en, mem_wr, if_done} !== 3'b100) begin
            errors++; $display("FAIL fetch_access2: en/wr/done=%b want 100", {mem_en, mem_wr, if_done});
        end
        nxt();
        checks++;
        if ({mem_en, if_done, d_done, busy} !== 4'b0101 || if_rdata !== 32'h00A0_0093) begin
            errors++; $display("FAIL fetch_done: en/ifd/dd/busy=%b rdata=%h want 0101 00a00093", {mem_en, if_done, d_done, busy}, if_rdata);
        end
        if_req = 1'b0;
        nxt();
        checks++;
        if ({busy, if_done, mem_en} !== 3'b000) begin
            errors++; $display("FAIL fetch_idle: busy/done/en=%b want 000", {busy, if_done, mem_en});
        end
    endtask

    task automatic test_load();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        nxt();
        checks++;
        if ({mem_en, mem_wr, grant_id} !== 3'b101 || mem_addr !== 32'h20) begin
            errors++; $display("FAIL load_grant: en/wr/gnt=%b addr=%h want 101 20", {mem_en, mem_wr, grant_id}, mem_addr);
        end
        nxt(2);
        checks++;
        if ({d_done, if_done} !== 2'b10 || d_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL load_done: dd/ifd=%b rdata=%h want 10 cafef00d", {d_done, if_done}, d_rdata);
        end
        d_req = 1'b0;
        nxt();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        nxt();
        checks++;
        if ({mem_en, mem_wr, grant_id} !== 3'b111 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_wr: en/wr/gnt=%b addr=%h wdata=%h want 111 100 deadbeef", {mem_en, mem_wr, grant_id}, mem_addr, mem_wdata);
        end
        nxt();
        checks++;
        if ({mem_en, mem_wr} !== 2'b10) begin
            errors++; $display("FAIL store_wr_once: en/wr=%b want 10", {mem_en, mem_wr});
        end
        nxt();
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 32'hCAFE_F00D || if_rdata !== 32'h00A0_0093) begin
            errors++; $display("FAIL store_done: dd=%b d_rdata=%h if_rdata=%h want 1 cafef00d 00a00093", d_done, d_rdata, if_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        nxt();
    endtask

    task automatic test_tie();
        int ifBase, dBase;
        doReset();
        ifBase = ifDoneCnt; dBase = dDoneCnt;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        nxt();
        checks++;
        if (grant_id !== 1'b0 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL tie_first: gnt=%b addr=%h want 0 10", grant_id, mem_addr);
        end
        nxt(2);
        if_req = 1'b0;
        nxt(2);
        checks++;
        if (grant_id !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL tie_second: gnt=%b en=%b addr=%h want 1 1 100", grant_id, mem_en, mem_addr);
        end
        nxt(2);
        d_req = 1'b0;
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL tie_load: dd=%b rdata=%h want 1 deadbeef", d_done, d_rdata);
        end
        nxt(3);
        checks++;
        if (ifDoneCnt - ifBase != 1 || dDoneCnt - dBase != 1) begin
            errors++; $display("FAIL tie_dones: if=%0d d=%0d want 1 1", ifDoneCnt - ifBase, dDoneCnt - dBase);
        end
    endtask

    task automatic test_fairness();
        int got = 0;
        int cyc = 0;
        int lastCyc = 0;
        logic prevBusy;
        logic expG;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        prevBusy = busy;
        while (got < 4 && cyc < 100) begin
            nxt();
            cyc++;
            if (busy === 1'b1 && prevBusy === 1'b0) begin
                expG = got[0];
                checks++;
                if (grant_id !== expG) begin
                    errors++; $display("FAIL fair_grant%0d: got %b want %b", got, grant_id, expG);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - lastCyc != 4) begin
                        errors++; $display("FAIL fair_spacing%0d: got %0d want 4", got, cyc - lastCyc);
                    end
                end
                lastCyc = cyc;
                got++;
            end
            prevBusy = busy;
        end
        checks++;
        if (got != 4) begin
            errors++; $display("FAIL fair_timeout: got %0d grants want 4", got);
        end
        if_req = 1'b0; d_req = 1'b0;
        nxt(6);
    endtask

    task automatic test_handshake();
        int ifBase;
        ifBase = ifDoneCnt;
        if_req = 1'b1; if_addr = 32'h14;
        nxt();
        if_addr = 32'h18;
        nxt();
        checks++;
        if (mem_addr !== 32'h14) begin
            errors++; $display("FAIL hs_addr_hold: got %h want 14", mem_addr);
        end
        nxt();
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL hs_first: done=%b rdata=%h want 1 11111111", if_done, if_rdata);
        end
        nxt();
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL hs_idle_gap: busy/en=%b%b want 00", busy, mem_en);
        end
        nxt();
        checks++;
        if (busy !== 1'b1 || mem_addr !== 32'h18) begin
            errors++; $display("FAIL hs_second: busy=%b addr=%h want 1 18", busy, mem_addr);
        end
        if_req = 1'b0;
        nxt(2);
        checks++;
        if (if_done !== 1'b1 || if_rdata !== 32'h2222_2222) begin
            errors++; $display("FAIL hs_second_done: done=%b rdata=%h want 1 22222222", if_done, if_rdata);
        end
        nxt(3);
        checks++;
        if (ifDoneCnt - ifBase != 2) begin
            errors++; $display("FAIL hs_count: got %0d dones want 2", ifDoneCnt - ifBase);
        end
    endtask

    task automatic test_reset_access();
        int dBase;
        int waitCyc = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h5555_AAAA;
        nxt();
        d_req = 1'b0; d_we = 1'b0;
        rst = 1'b1;
        dBase = dDoneCnt;
        #1;
        checks++;
        if ({busy, mem_en, mem_wr} !== 3'b000) begin
            errors++; $display("FAIL rst_access: busy/en/wr=%b want 000", {busy, mem_en, mem_wr});
        end
        nxt(2);
        rst = 1'b0;
        nxt(3);
        checks++;
        if (dDoneCnt != dBase) begin
            errors++; $display("FAIL rst_no_done: got %0d dones want 0", dDoneCnt - dBase);
        end
        d_req = 1'b1; d_addr = 32'h100;
        while (d_done !== 1'b1 && waitCyc < 20) begin
            nxt();
            waitCyc++;
        end
        d_req = 1'b0;
        checks++;
        if (waitCyc != 3 || d_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rst_recover: cycles=%0d rdata=%h want 3 deadbeef", waitCyc, d_rdata);
        end
        nxt(2);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) memArr[i] = 32'h0;
        memArr[4] = 32'h00A0_0093;
        memArr[5] = 32'h1111_1111;
        memArr[6] = 32'h2222_2222;
        memArr[8] = 32'hCAFE_F00D;
        nxt();
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_tie();
        test_fairness();
        test_handshake();
        test_reset_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
